// File: rtl/bp_me_axi_subordinate_pkg.sv
// Shared types for the AXI4 subordinate to BedRock Stream bridge.
//   - BedRock configuration (physical address width, fill width, payload ids)
//   - AXI response and burst encodings
//   - BedRock mem message type / size encodings and header struct
//   - Bridge FSM state encoding
//   - axsize to BedRock message-size conversion
package bp_me_axi_subordinate_pkg;

    localparam int paddr_width_gp        = 40;
    localparam int bedrock_fill_width_gp = 64;
    localparam int lce_id_width_gp       = 8;
    localparam int did_width_gp          = 4;

    typedef enum logic [1:0] {
        e_axi_resp_okay   = 2'b00,
        e_axi_resp_exokay = 2'b01,
        e_axi_resp_slverr = 2'b10,
        e_axi_resp_decerr = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        e_axi_burst_fixed = 2'b00,
        e_axi_burst_incr  = 2'b01,
        e_axi_burst_wrap  = 2'b10
    } axi_burst_e;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [did_width_gp-1:0]    did;
        logic [lce_id_width_gp-1:0] lce_id;
    } bp_bedrock_mem_payload_s;

    typedef struct packed {
        bp_bedrock_mem_payload_s    payload;
        bp_bedrock_msg_size_e       size;
        logic [paddr_width_gp-1:0]  addr;
        logic [3:0]                 subop;
        bp_bedrock_mem_type_e       msg_type;
    } bp_bedrock_mem_header_s;

    localparam int mem_header_width_gp = $bits(bp_bedrock_mem_header_s);

    typedef enum logic [2:0] {
        e_idle,
        e_wcollect,
        e_fwd,
        e_rev,
        e_bresp,
        e_rresp,
        e_err
    } bridge_state_e;

    // AXI axsize is log2(bytes), which is also how BedRock encodes size.
    function automatic bp_bedrock_msg_size_e axsize_to_msg_size(input logic [2:0] axsize);
        case (axsize)
            3'd0:    return e_bedrock_msg_size_1;
            3'd1:    return e_bedrock_msg_size_2;
            3'd2:    return e_bedrock_msg_size_4;
            3'd3:    return e_bedrock_msg_size_8;
            3'd4:    return e_bedrock_msg_size_16;
            3'd5:    return e_bedrock_msg_size_32;
            3'd6:    return e_bedrock_msg_size_64;
            default: return e_bedrock_msg_size_128;
        endcase
    endfunction

endpackage

// File: rtl/bp_me_axi_subordinate_arb.sv
// Two-input round-robin arbiter.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   en_i             : arbitration enabled this cycle
//   req_i[1:0]       : requests, bit 0 = write channel, bit 1 = read channel
//   gnt_o[1:0]       : one-hot grant (at most one bit set)
// rr_r selects the winner on contention (0 favours bit 0) and flips on every grant.
module bp_me_axi_subordinate_arb (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic rr_r;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i[0] && (!req_i[1] || !rr_r))
                gnt_o = 2'b01;
            else if (req_i[1])
                gnt_o = 2'b10;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            rr_r <= 1'b0;
        else if (|gnt_o)
            rr_r <= ~rr_r;
    end

endmodule

// File: rtl/bp_me_axi_subordinate.sv
// AXI4 subordinate to BedRock Stream bridge, one outstanding transaction.
//   clk_i, reset_n_i       : clock, asynchronous active-low reset
//   s_axi_aw* / s_axi_w*   : write address / data from the external manager
//   s_axi_b*               : write response
//   s_axi_ar* / s_axi_r*   : read address / read data
//   mem_fwd_*              : BedRock request (uc_rd / uc_wr), ready-valid
//   mem_rev_*              : BedRock response, ready-valid
// Single-beat requests go out as one mem_fwd and return one B or R. Bursts
// (len != 0) never reach BedRock: W beats are drained / R beats generated
// locally with SLVERR.
module bp_me_axi_subordinate
    import bp_me_axi_subordinate_pkg::*;
#(
    parameter int                         s_axi_data_width_p = 64,
    parameter int                         s_axi_addr_width_p = 64,
    parameter int                         s_axi_id_width_p   = 1,
    parameter logic [lce_id_width_gp-1:0] lce_id_p           = '0,
    parameter logic [did_width_gp-1:0]    did_p              = '0
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,

    input  logic [s_axi_addr_width_p-1:0]   s_axi_awaddr_i,
    input  logic                            s_axi_awvalid_i,
    output logic                            s_axi_awready_o,
    input  logic [s_axi_id_width_p-1:0]     s_axi_awid_i,
    input  logic [7:0]                      s_axi_awlen_i,
    input  logic [2:0]                      s_axi_awsize_i,
    input  logic [1:0]                      s_axi_awburst_i,
    input  logic                            s_axi_awlock_i,
    input  logic [3:0]                      s_axi_awcache_i,
    input  logic [2:0]                      s_axi_awprot_i,
    input  logic [3:0]                      s_axi_awqos_i,
    input  logic [3:0]                      s_axi_awregion_i,

    input  logic [s_axi_data_width_p-1:0]   s_axi_wdata_i,
    input  logic [s_axi_data_width_p/8-1:0] s_axi_wstrb_i,
    input  logic                            s_axi_wlast_i,
    input  logic                            s_axi_wvalid_i,
    output logic                            s_axi_wready_o,

    output logic [s_axi_id_width_p-1:0]     s_axi_bid_o,
    output logic [1:0]                      s_axi_bresp_o,
    output logic                            s_axi_bvalid_o,
    input  logic                            s_axi_bready_i,

    input  logic [s_axi_addr_width_p-1:0]   s_axi_araddr_i,
    input  logic                            s_axi_arvalid_i,
    output logic                            s_axi_arready_o,
    input  logic [s_axi_id_width_p-1:0]     s_axi_arid_i,
    input  logic [7:0]                      s_axi_arlen_i,
    input  logic [2:0]                      s_axi_arsize_i,
    input  logic [1:0]                      s_axi_arburst_i,
    input  logic                            s_axi_arlock_i,
    input  logic [3:0]                      s_axi_arcache_i,
    input  logic [2:0]                      s_axi_arprot_i,
    input  logic [3:0]                      s_axi_arqos_i,
    input  logic [3:0]                      s_axi_arregion_i,

    output logic [s_axi_data_width_p-1:0]   s_axi_rdata_o,
    output logic [s_axi_id_width_p-1:0]     s_axi_rid_o,
    output logic [1:0]                      s_axi_rresp_o,
    output logic                            s_axi_rlast_o,
    output logic                            s_axi_rvalid_o,
    input  logic                            s_axi_rready_i,

    output logic [mem_header_width_gp-1:0]  mem_fwd_header_o,
    output logic [bedrock_fill_width_gp-1:0] mem_fwd_data_o,
    output logic                            mem_fwd_v_o,
    input  logic                            mem_fwd_ready_and_i,

    input  logic [mem_header_width_gp-1:0]  mem_rev_header_i,
    input  logic [bedrock_fill_width_gp-1:0] mem_rev_data_i,
    input  logic                            mem_rev_v_i,
    output logic                            mem_rev_ready_and_o
);

    bridge_state_e                    state_r;
    logic                             is_wr_r;
    logic                             err_r;
    logic [paddr_width_gp-1:0]        addr_r;
    logic [s_axi_id_width_p-1:0]      id_r;
    logic [2:0]                       size_r;
    logic [7:0]                       cnt_r;
    logic [s_axi_data_width_p-1:0]    wdata_r;
    logic [s_axi_data_width_p-1:0]    rdata_r;
    logic [1:0]                       gnt;

    // Gating with reset keeps both readies low while reset is held even
    // though the arbiter grant is combinational on the valids.
    bp_me_axi_subordinate_arb arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      ((state_r == e_idle) && reset_n_i),
        .req_i     ({s_axi_arvalid_i, s_axi_awvalid_i}),
        .gnt_o     (gnt)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_idle;
            is_wr_r <= 1'b0;
            err_r   <= 1'b0;
            addr_r  <= '0;
            id_r    <= '0;
            size_r  <= '0;
            cnt_r   <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
        end else begin
            case (state_r)
                e_idle: begin
                    // rdata/wdata clear on every grant so reads forward zero
                    // data and error R beats return zero data.
                    if (gnt[0]) begin
                        is_wr_r <= 1'b1;
                        addr_r  <= s_axi_awaddr_i[paddr_width_gp-1:0];
                        id_r    <= s_axi_awid_i;
                        size_r  <= s_axi_awsize_i;
                        cnt_r   <= s_axi_awlen_i;
                        err_r   <= (s_axi_awlen_i != 8'd0);
                        wdata_r <= '0;
                        rdata_r <= '0;
                        state_r <= (s_axi_awlen_i != 8'd0) ? e_err : e_wcollect;
                    end else if (gnt[1]) begin
                        is_wr_r <= 1'b0;
                        addr_r  <= s_axi_araddr_i[paddr_width_gp-1:0];
                        id_r    <= s_axi_arid_i;
                        size_r  <= s_axi_arsize_i;
                        cnt_r   <= s_axi_arlen_i;
                        err_r   <= (s_axi_arlen_i != 8'd0);
                        wdata_r <= '0;
                        rdata_r <= '0;
                        state_r <= (s_axi_arlen_i != 8'd0) ? e_err : e_fwd;
                    end
                end
                e_wcollect: begin
                    if (s_axi_wvalid_i) begin
                        wdata_r <= s_axi_wdata_i;
                        state_r <= e_fwd;
                    end
                end
                e_fwd: begin
                    if (mem_fwd_ready_and_i)
                        state_r <= e_rev;
                end
                e_rev: begin
                    if (mem_rev_v_i) begin
                        rdata_r <= mem_rev_data_i;
                        state_r <= is_wr_r ? e_bresp : e_rresp;
                    end
                end
                e_bresp: begin
                    if (s_axi_bready_i)
                        state_r <= e_idle;
                end
                e_rresp: begin
                    if (s_axi_rready_i)
                        state_r <= e_idle;
                end
                e_err: begin
                    // cnt_r holds the beats remaining after the current one,
                    // so len=255 yields 256 beats and stops at zero.
                    if (is_wr_r) begin
                        if (s_axi_wvalid_i) begin
                            if (cnt_r == 8'd0)
                                state_r <= e_bresp;
                            else
                                cnt_r <= cnt_r - 8'd1;
                        end
                    end else if (s_axi_rready_i) begin
                        if (cnt_r == 8'd0)
                            state_r <= e_idle;
                        else
                            cnt_r <= cnt_r - 8'd1;
                    end
                end
                default: state_r <= e_idle;
            endcase
        end
    end

    bp_bedrock_mem_header_s fwd_hdr;

    always_comb begin
        fwd_hdr                = '0;
        fwd_hdr.msg_type       = is_wr_r ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
        fwd_hdr.addr           = addr_r;
        fwd_hdr.size           = axsize_to_msg_size(size_r);
        fwd_hdr.payload.lce_id = lce_id_p;
        fwd_hdr.payload.did    = did_p;
    end

    assign mem_fwd_header_o    = fwd_hdr;
    assign mem_fwd_data_o      = wdata_r;
    assign mem_fwd_v_o         = (state_r == e_fwd);
    assign mem_rev_ready_and_o = (state_r == e_rev);

    assign s_axi_awready_o = gnt[0];
    assign s_axi_arready_o = gnt[1];
    assign s_axi_wready_o  = (state_r == e_wcollect) || ((state_r == e_err) && is_wr_r);

    assign s_axi_bvalid_o  = (state_r == e_bresp);
    assign s_axi_bid_o     = id_r;
    assign s_axi_bresp_o   = err_r ? e_axi_resp_slverr : e_axi_resp_okay;

    assign s_axi_rvalid_o  = (state_r == e_rresp) || ((state_r == e_err) && !is_wr_r);
    assign s_axi_rdata_o   = rdata_r;
    assign s_axi_rid_o     = id_r;
    assign s_axi_rresp_o   = err_r ? e_axi_resp_slverr : e_axi_resp_okay;
    assign s_axi_rlast_o   = (state_r == e_rresp) || ((state_r == e_err) && (cnt_r == 8'd0));

    // Inputs the bridge deliberately ignores: sideband, burst type, wlast,
    // strobes (size alone sets the BedRock mask), truncated address bits and
    // the response header.
    wire unused_inputs = &{1'b0,
        s_axi_awaddr_i[s_axi_addr_width_p-1:paddr_width_gp],
        s_axi_araddr_i[s_axi_addr_width_p-1:paddr_width_gp],
        s_axi_awburst_i, s_axi_arburst_i, s_axi_wlast_i, s_axi_wstrb_i,
        s_axi_awlock_i, s_axi_awcache_i, s_axi_awprot_i, s_axi_awqos_i, s_axi_awregion_i,
        s_axi_arlock_i, s_axi_arcache_i, s_axi_arprot_i, s_axi_arqos_i, s_axi_arregion_i,
        mem_rev_header_i};

endmodule

// File: tb/tb_bp_me_axi_subordinate.sv
// Directed bench for bp_me_axi_subordinate.
module tb_bp_me_axi_subordinate;
    import bp_me_axi_subordinate_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [63:0] s_axi_awaddr_i;
    logic        s_axi_awvalid_i;
    logic        s_axi_awready_o;
    logic [0:0]  s_axi_awid_i;
    logic [7:0]  s_axi_awlen_i;
    logic [2:0]  s_axi_awsize_i;
    logic [1:0]  s_axi_awburst_i;
    logic [63:0] s_axi_wdata_i;
    logic [7:0]  s_axi_wstrb_i;
    logic        s_axi_wlast_i;
    logic        s_axi_wvalid_i;
    logic        s_axi_wready_o;
    logic [0:0]  s_axi_bid_o;
    logic [1:0]  s_axi_bresp_o;
    logic        s_axi_bvalid_o;
    logic        s_axi_bready_i;
    logic [63:0] s_axi_araddr_i;
    logic        s_axi_arvalid_i;
    logic        s_axi_arready_o;
    logic [0:0]  s_axi_arid_i;
    logic [7:0]  s_axi_arlen_i;
    logic [2:0]  s_axi_arsize_i;
    logic [1:0]  s_axi_arburst_i;
    logic [63:0] s_axi_rdata_o;
    logic [0:0]  s_axi_rid_o;
    logic [1:0]  s_axi_rresp_o;
    logic        s_axi_rlast_o;
    logic        s_axi_rvalid_o;
    logic        s_axi_rready_i;
    logic [mem_header_width_gp-1:0] mem_fwd_header_o;
    logic [63:0] mem_fwd_data_o;
    logic        mem_fwd_v_o;
    logic        mem_fwd_ready_and_i;
    logic [mem_header_width_gp-1:0] mem_rev_header_i;
    logic [63:0] mem_rev_data_i;
    logic        mem_rev_v_i;
    logic        mem_rev_ready_and_o;

    int n_cmp  = 0;
    int n_fail = 0;

    bp_bedrock_mem_header_s hdr;
    assign hdr = bp_bedrock_mem_header_s'(mem_fwd_header_o);

    bp_me_axi_subordinate dut (
        .clk_i               (clk_i),
        .reset_n_i           (reset_n_i),
        .s_axi_awaddr_i      (s_axi_awaddr_i),
        .s_axi_awvalid_i     (s_axi_awvalid_i),
        .s_axi_awready_o     (s_axi_awready_o),
        .s_axi_awid_i        (s_axi_awid_i),
        .s_axi_awlen_i       (s_axi_awlen_i),
        .s_axi_awsize_i      (s_axi_awsize_i),
        .s_axi_awburst_i     (s_axi_awburst_i),
        .s_axi_awlock_i      (1'b0),
        .s_axi_awcache_i     (4'h0),
        .s_axi_awprot_i      (3'h0),
        .s_axi_awqos_i       (4'h0),
        .s_axi_awregion_i    (4'h0),
        .s_axi_wdata_i       (s_axi_wdata_i),
        .s_axi_wstrb_i       (s_axi_wstrb_i),
        .s_axi_wlast_i       (s_axi_wlast_i),
        .s_axi_wvalid_i      (s_axi_wvalid_i),
        .s_axi_wready_o      (s_axi_wready_o),
        .s_axi_bid_o         (s_axi_bid_o),
        .s_axi_bresp_o       (s_axi_bresp_o),
        .s_axi_bvalid_o      (s_axi_bvalid_o),
        .s_axi_bready_i      (s_axi_bready_i),
        .s_axi_araddr_i      (s_axi_araddr_i),
        .s_axi_arvalid_i     (s_axi_arvalid_i),
        .s_axi_arready_o     (s_axi_arready_o),
        .s_axi_arid_i        (s_axi_arid_i),
        .s_axi_arlen_i       (s_axi_arlen_i),
        .s_axi_arsize_i      (s_axi_arsize_i),
        .s_axi_arburst_i     (s_axi_arburst_i),
        .s_axi_arlock_i      (1'b0),
        .s_axi_arcache_i     (4'h0),
        .s_axi_arprot_i      (3'h0),
        .s_axi_arqos_i       (4'h0),
        .s_axi_arregion_i    (4'h0),
        .s_axi_rdata_o       (s_axi_rdata_o),
        .s_axi_rid_o         (s_axi_rid_o),
        .s_axi_rresp_o       (s_axi_rresp_o),
        .s_axi_rlast_o       (s_axi_rlast_o),
        .s_axi_rvalid_o      (s_axi_rvalid_o),
        .s_axi_rready_i      (s_axi_rready_i),
        .mem_fwd_header_o    (mem_fwd_header_o),
        .mem_fwd_data_o      (mem_fwd_data_o),
        .mem_fwd_v_o         (mem_fwd_v_o),
        .mem_fwd_ready_and_i (mem_fwd_ready_and_i),
        .mem_rev_header_i    (mem_rev_header_i),
        .mem_rev_data_i      (mem_rev_data_i),
        .mem_rev_v_i         (mem_rev_v_i),
        .mem_rev_ready_and_o (mem_rev_ready_and_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle_inputs();
        s_axi_awaddr_i = '0; s_axi_awvalid_i = 0; s_axi_awid_i = '0; s_axi_awlen_i = '0;
        s_axi_awsize_i = '0; s_axi_awburst_i = 2'b01;
        s_axi_wdata_i = '0; s_axi_wstrb_i = '0; s_axi_wlast_i = 0; s_axi_wvalid_i = 0;
        s_axi_bready_i = 1;
        s_axi_araddr_i = '0; s_axi_arvalid_i = 0; s_axi_arid_i = '0; s_axi_arlen_i = '0;
        s_axi_arsize_i = '0; s_axi_arburst_i = 2'b01; s_axi_rready_i = 1;
        mem_fwd_ready_and_i = 1; mem_rev_header_i = '0; mem_rev_data_i = '0; mem_rev_v_i = 0;
    endtask

    task automatic do_reset();
        reset_n_i = 0;
        tick();
        reset_n_i = 1;
        tick();
    endtask

    function automatic bp_bedrock_mem_header_s mk_hdr(input bp_bedrock_mem_type_e t,
                                                      input logic [39:0] a,
                                                      input bp_bedrock_msg_size_e s);
        bp_bedrock_mem_header_s h;
        h = '0;
        h.msg_type = t;
        h.addr = a;
        h.size = s;
        return h;
    endfunction

    // valids and readies low while reset is held, even with requests pending
    task automatic test_reset();
        idle_inputs();
        reset_n_i = 0;
        s_axi_awvalid_i = 1; s_axi_arvalid_i = 1; s_axi_wvalid_i = 1;
        #12;
        n_cmp++;
        if ({s_axi_awready_o, s_axi_arready_o, s_axi_wready_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_readies: got %b want 000", {s_axi_awready_o, s_axi_arready_o, s_axi_wready_o});
        end
        n_cmp++;
        if ({s_axi_bvalid_o, s_axi_rvalid_o, mem_fwd_v_o, mem_rev_ready_and_o} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_valids: got %b want 0000", {s_axi_bvalid_o, s_axi_rvalid_o, mem_fwd_v_o, mem_rev_ready_and_o});
        end
        n_cmp++;
        if (s_axi_rdata_o !== 64'h0 || mem_fwd_data_o !== 64'h0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", s_axi_rdata_o, mem_fwd_data_o);
        end
        idle_inputs();
        tick();
        reset_n_i = 1;
        tick();
        n_cmp++;
        if (s_axi_rvalid_o !== 1'b0 || s_axi_bvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got r=%b b=%b want 0/0", s_axi_rvalid_o, s_axi_bvalid_o);
        end
    endtask

    task automatic test_read();
        s_axi_araddr_i = 64'h8000_0010; s_axi_arsize_i = 3'd3; s_axi_arid_i = 1'b1;
        s_axi_arlen_i = 8'd0; s_axi_arvalid_i = 1;
        #1;
        n_cmp++;
        if (s_axi_arready_o !== 1'b1 || s_axi_awready_o !== 1'b0) begin
            n_fail++; $display("FAIL rd_arready: got ar=%b aw=%b want 1/0", s_axi_arready_o, s_axi_awready_o);
        end
        tick();
        s_axi_arvalid_i = 0;
        n_cmp++;
        if (mem_fwd_v_o !== 1'b1) begin
            n_fail++; $display("FAIL rd_fwd_v: got %b want 1", mem_fwd_v_o);
        end
        n_cmp++;
        if (hdr !== mk_hdr(e_bedrock_mem_uc_rd, 40'h00_8000_0010, e_bedrock_msg_size_8)) begin
            n_fail++; $display("FAIL rd_fwd_hdr: got %h want %h", hdr, mk_hdr(e_bedrock_mem_uc_rd, 40'h00_8000_0010, e_bedrock_msg_size_8));
        end
        n_cmp++;
        if (mem_fwd_data_o !== 64'h0) begin
            n_fail++; $display("FAIL rd_fwd_data: got %h want 0", mem_fwd_data_o);
        end
        tick();
        n_cmp++;
        if (mem_rev_ready_and_o !== 1'b1 || mem_fwd_v_o !== 1'b0 || s_axi_rvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL rd_rev_state: got rdy=%b fwd=%b rv=%b want 1/0/0", mem_rev_ready_and_o, mem_fwd_v_o, s_axi_rvalid_o);
        end
        mem_rev_v_i = 1; mem_rev_data_i = 64'hDEADBEEF_CAFEF00D;
        tick();
        mem_rev_v_i = 0; mem_rev_data_i = '0;
        n_cmp++;
        if (s_axi_rvalid_o !== 1'b1) begin
            n_fail++; $display("FAIL rd_latency: rvalid got %b want 1 three cycles after AR", s_axi_rvalid_o);
        end
        n_cmp++;
        if (s_axi_rdata_o !== 64'hDEADBEEF_CAFEF00D) begin
            n_fail++; $display("FAIL rd_data: got %h want deadbeefcafef00d", s_axi_rdata_o);
        end
        n_cmp++;
        if ({s_axi_rid_o, s_axi_rresp_o, s_axi_rlast_o} !== {1'b1, 2'b00, 1'b1}) begin
            n_fail++; $display("FAIL rd_resp: got id=%b resp=%b last=%b want 1/00/1", s_axi_rid_o, s_axi_rresp_o, s_axi_rlast_o);
        end
        tick();
        n_cmp++;
        if (s_axi_rvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL rd_done: rvalid got %b want 0", s_axi_rvalid_o);
        end
    endtask

    task automatic test_write();
        s_axi_wvalid_i = 1; s_axi_wdata_i = 64'hAAAA_AAAA_AAAA_AAAA;
        #1;
        n_cmp++;
        if (s_axi_wready_o !== 1'b0) begin
            n_fail++; $display("FAIL wr_early_w: wready got %b want 0", s_axi_wready_o);
        end
        s_axi_wvalid_i = 0;
        s_axi_awaddr_i = 64'h1004; s_axi_awsize_i = 3'd2; s_axi_awid_i = 1'b0;
        s_axi_awlen_i = 8'd0; s_axi_awvalid_i = 1;
        #1;
        n_cmp++;
        if (s_axi_awready_o !== 1'b1 || s_axi_arready_o !== 1'b0) begin
            n_fail++; $display("FAIL wr_awready: got aw=%b ar=%b want 1/0", s_axi_awready_o, s_axi_arready_o);
        end
        tick();
        s_axi_awvalid_i = 0;
        tick();
        tick();
        n_cmp++;
        if (s_axi_wready_o !== 1'b1 || mem_fwd_v_o !== 1'b0) begin
            n_fail++; $display("FAIL wr_wait_w: got wready=%b fwd=%b want 1/0", s_axi_wready_o, mem_fwd_v_o);
        end
        s_axi_wvalid_i = 1; s_axi_wdata_i = 64'h12345678_00000000; s_axi_wstrb_i = 8'hF0; s_axi_wlast_i = 1;
        tick();
        s_axi_wvalid_i = 0; s_axi_wdata_i = '0; s_axi_wstrb_i = '0;
        n_cmp++;
        if (mem_fwd_v_o !== 1'b1 || hdr !== mk_hdr(e_bedrock_mem_uc_wr, 40'h1004, e_bedrock_msg_size_4)) begin
            n_fail++; $display("FAIL wr_fwd_hdr: got v=%b hdr=%h want 1/%h", mem_fwd_v_o, hdr, mk_hdr(e_bedrock_mem_uc_wr, 40'h1004, e_bedrock_msg_size_4));
        end
        n_cmp++;
        if (mem_fwd_data_o !== 64'h12345678_00000000) begin
            n_fail++; $display("FAIL wr_fwd_data: got %h want 1234567800000000", mem_fwd_data_o);
        end
        tick();
        n_cmp++;
        if (s_axi_bvalid_o !== 1'b0 || mem_rev_ready_and_o !== 1'b1) begin
            n_fail++; $display("FAIL wr_b_early: got b=%b revrdy=%b want 0/1", s_axi_bvalid_o, mem_rev_ready_and_o);
        end
        mem_rev_v_i = 1;
        tick();
        mem_rev_v_i = 0;
        n_cmp++;
        if ({s_axi_bvalid_o, s_axi_bresp_o, s_axi_bid_o} !== {1'b1, 2'b00, 1'b0}) begin
            n_fail++; $display("FAIL wr_bresp: got v=%b resp=%b id=%b want 1/00/0", s_axi_bvalid_o, s_axi_bresp_o, s_axi_bid_o);
        end
        tick();
        n_cmp++;
        if (s_axi_bvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL wr_done: bvalid got %b want 0", s_axi_bvalid_o);
        end
    endtask

    task automatic test_back_to_back();
        bit got;
        do_reset();
        s_axi_awaddr_i = 64'h2000; s_axi_awsize_i = 3'd3; s_axi_awvalid_i = 1;
        s_axi_araddr_i = 64'h3000; s_axi_arsize_i = 3'd3; s_axi_arvalid_i = 1;
        s_axi_wvalid_i = 1; s_axi_wdata_i = 64'h5555; s_axi_wlast_i = 1;
        for (int t = 0; t < 8; t++) begin
            got = 0;
            for (int c = 0; c < 20; c++) begin
                if (mem_fwd_v_o) begin got = 1; break; end
                tick();
            end
            n_cmp++;
            if (!got) begin
                n_fail++; $display("FAIL b2b_timeout[%0d]: got no mem_fwd want one within 20 cycles", t);
            end
            n_cmp++;
            if (hdr.msg_type !== ((t % 2 == 0) ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd)) begin
                n_fail++; $display("FAIL b2b_order[%0d]: got %0d want %0d", t, hdr.msg_type, (t % 2 == 0) ? 3 : 2);
            end
            n_cmp++;
            if (hdr.addr !== ((t % 2 == 0) ? 40'h2000 : 40'h3000)) begin
                n_fail++; $display("FAIL b2b_addr[%0d]: got %h want %h", t, hdr.addr, (t % 2 == 0) ? 40'h2000 : 40'h3000);
            end
            tick();
            n_cmp++;
            if (mem_fwd_v_o !== 1'b0) begin
                n_fail++; $display("FAIL b2b_outstanding[%0d]: fwd_v got %b want 0 while awaiting rev", t, mem_fwd_v_o);
            end
            mem_rev_v_i = 1;
            tick();
            mem_rev_v_i = 0;
            if (t == 7) begin
                s_axi_awvalid_i = 0; s_axi_arvalid_i = 0; s_axi_wvalid_i = 0;
            end
        end
        tick();
        tick();
        n_cmp++;
        if ({mem_fwd_v_o, s_axi_rvalid_o, s_axi_bvalid_o} !== 3'b000) begin
            n_fail++; $display("FAIL b2b_drain: got %b want 000", {mem_fwd_v_o, s_axi_rvalid_o, s_axi_bvalid_o});
        end
    endtask

    task automatic test_err_read();
        s_axi_araddr_i = 64'h100; s_axi_arlen_i = 8'd3; s_axi_arid_i = 1'b1; s_axi_arvalid_i = 1;
        s_axi_rready_i = 1;
        tick();
        s_axi_arvalid_i = 0; s_axi_arlen_i = 0;
        for (int b = 0; b < 4; b++) begin
            n_cmp++;
            if ({s_axi_rvalid_o, s_axi_rresp_o, s_axi_rid_o} !== {1'b1, 2'b10, 1'b1}) begin
                n_fail++; $display("FAIL err_rd_beat[%0d]: got v=%b resp=%b id=%b want 1/10/1", b, s_axi_rvalid_o, s_axi_rresp_o, s_axi_rid_o);
            end
            n_cmp++;
            if (s_axi_rlast_o !== (b == 3)) begin
                n_fail++; $display("FAIL err_rd_last[%0d]: got %b want %b", b, s_axi_rlast_o, b == 3);
            end
            n_cmp++;
            if (s_axi_rdata_o !== 64'h0 || mem_fwd_v_o !== 1'b0) begin
                n_fail++; $display("FAIL err_rd_data[%0d]: got data=%h fwd=%b want 0/0", b, s_axi_rdata_o, mem_fwd_v_o);
            end
            tick();
        end
        n_cmp++;
        if (s_axi_rvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL err_rd_end: rvalid got %b want 0", s_axi_rvalid_o);
        end
    endtask

    task automatic test_err_write();
        int missing = 0;
        int early_b = 0;
        int fwd_seen = 0;
        s_axi_awaddr_i = 64'h200; s_axi_awlen_i = 8'd255; s_axi_awid_i = 1'b1; s_axi_awvalid_i = 1;
        s_axi_bready_i = 0;
        tick();
        s_axi_awvalid_i = 0; s_axi_awlen_i = 0;
        s_axi_wvalid_i = 1; s_axi_wdata_i = 64'hFFFF;
        for (int b = 0; b < 256; b++) begin
            if (s_axi_wready_o !== 1'b1) missing++;
            if (s_axi_bvalid_o !== 1'b0) early_b++;
            if (mem_fwd_v_o !== 1'b0) fwd_seen++;
            tick();
        end
        s_axi_wvalid_i = 0;
        n_cmp++;
        if (missing != 0 || early_b != 0) begin
            n_fail++; $display("FAIL err_wr_beats: got %0d unready beats, %0d early B want 0/0", missing, early_b);
        end
        n_cmp++;
        if (fwd_seen != 0) begin
            n_fail++; $display("FAIL err_wr_nofwd: got %0d fwd cycles want 0", fwd_seen);
        end
        n_cmp++;
        if ({s_axi_bvalid_o, s_axi_bresp_o, s_axi_bid_o, s_axi_wready_o} !== {1'b1, 2'b10, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL err_wr_b: got v=%b resp=%b id=%b wr=%b want 1/10/1/0", s_axi_bvalid_o, s_axi_bresp_o, s_axi_bid_o, s_axi_wready_o);
        end
        tick();
        n_cmp++;
        if (s_axi_bvalid_o !== 1'b1) begin
            n_fail++; $display("FAIL err_wr_bhold: bvalid got %b want 1", s_axi_bvalid_o);
        end
        s_axi_bready_i = 1;
        tick();
        n_cmp++;
        if (s_axi_bvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL err_wr_end: bvalid got %b want 0", s_axi_bvalid_o);
        end
    endtask

    task automatic test_backpressure();
        s_axi_araddr_i = 64'h4000; s_axi_arsize_i = 3'd3; s_axi_arid_i = 1'b0; s_axi_arvalid_i = 1;
        mem_fwd_ready_and_i = 0; s_axi_rready_i = 0;
        tick();
        s_axi_arvalid_i = 0;
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (mem_fwd_v_o !== 1'b1 || hdr !== mk_hdr(e_bedrock_mem_uc_rd, 40'h4000, e_bedrock_msg_size_8)) begin
                n_fail++; $display("FAIL bp_fwd_hold[%0d]: got v=%b hdr=%h want 1/%h", c, mem_fwd_v_o, hdr, mk_hdr(e_bedrock_mem_uc_rd, 40'h4000, e_bedrock_msg_size_8));
            end
            tick();
        end
        mem_fwd_ready_and_i = 1;
        tick();
        n_cmp++;
        if (mem_fwd_v_o !== 1'b0 || mem_rev_ready_and_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_no_dup: got fwd=%b revrdy=%b want 0/1", mem_fwd_v_o, mem_rev_ready_and_o);
        end
        mem_rev_v_i = 1; mem_rev_data_i = 64'h0123_4567_89AB_CDEF;
        tick();
        mem_rev_v_i = 0; mem_rev_data_i = '0;
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (s_axi_rvalid_o !== 1'b1 || s_axi_rdata_o !== 64'h0123_4567_89AB_CDEF || s_axi_rlast_o !== 1'b1) begin
                n_fail++; $display("FAIL bp_r_hold[%0d]: got v=%b data=%h last=%b want 1/0123456789abcdef/1", c, s_axi_rvalid_o, s_axi_rdata_o, s_axi_rlast_o);
            end
            tick();
        end
        s_axi_rready_i = 1;
        tick();
        n_cmp++;
        if (s_axi_rvalid_o !== 1'b0 || mem_fwd_v_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_done: got rv=%b fwd=%b want 0/0", s_axi_rvalid_o, mem_fwd_v_o);
        end
    endtask

    task automatic test_reset_mid();
        s_axi_araddr_i = 64'h5000; s_axi_arsize_i = 3'd3; s_axi_arid_i = 1'b1; s_axi_arvalid_i = 1;
        tick();
        s_axi_arvalid_i = 0;
        tick();
        n_cmp++;
        if (mem_rev_ready_and_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_in_rev: revrdy got %b want 1", mem_rev_ready_and_o);
        end
        #1;
        reset_n_i = 0;
        #1;
        n_cmp++;
        if ({mem_rev_ready_and_o, mem_fwd_v_o, s_axi_rvalid_o, s_axi_bvalid_o, s_axi_wready_o} !== 5'b00000) begin
            n_fail++; $display("FAIL rst_mid_async: got %b want 00000", {mem_rev_ready_and_o, mem_fwd_v_o, s_axi_rvalid_o, s_axi_bvalid_o, s_axi_wready_o});
        end
        #2;
        reset_n_i = 1;
        mem_rev_v_i = 1; mem_rev_data_i = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        tick();
        n_cmp++;
        if (s_axi_rvalid_o !== 1'b0 || mem_rev_ready_and_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_abandon: got rv=%b revrdy=%b want 0/0", s_axi_rvalid_o, mem_rev_ready_and_o);
        end
        mem_rev_v_i = 0; mem_rev_data_i = '0;
        s_axi_araddr_i = 64'h6008; s_axi_arid_i = 1'b0; s_axi_arvalid_i = 1;
        tick();
        s_axi_arvalid_i = 0;
        n_cmp++;
        if (mem_fwd_v_o !== 1'b1 || hdr.addr !== 40'h6008) begin
            n_fail++; $display("FAIL rst_mid_next_fwd: got v=%b addr=%h want 1/6008", mem_fwd_v_o, hdr.addr);
        end
        tick();
        mem_rev_v_i = 1; mem_rev_data_i = 64'h0000_1111_2222_3333;
        tick();
        mem_rev_v_i = 0;
        n_cmp++;
        if ({s_axi_rvalid_o, s_axi_rresp_o, s_axi_rid_o} !== {1'b1, 2'b00, 1'b0} || s_axi_rdata_o !== 64'h0000_1111_2222_3333) begin
            n_fail++; $display("FAIL rst_mid_next_r: got v=%b resp=%b id=%b data=%h want 1/00/0/0000111122223333", s_axi_rvalid_o, s_axi_rresp_o, s_axi_rid_o, s_axi_rdata_o);
        end
        tick();
    endtask

    initial begin
        idle_inputs();
        reset_n_i = 0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_err_read();
        test_err_write();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
